// File: rtl/mem_2rw_uram_pkg.sv
// Shared types and limits for the dual-port UltraRAM line store.
// Holds the init FSM encoding and the legal read-latency window.
package mem_2rw_uram_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      READY = 1'b1
   } mem_state_e;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 4;

endpackage

// File: rtl/mem_2rw_uram_if.sv
// Port-pair bundle for the dual-port line store: two request ports plus qualified read data.
// Master drives requests; slave (the memory) returns data, valids and init_done.
interface mem_2rw_uram_if
   import mem_2rw_uram_pkg::*;
#(
   parameter int BYTES_PER_LINE = 8,
   parameter int ADDR_WIDTH     = 12
);
   localparam int LINE_SIZE = 8 * BYTES_PER_LINE;

   logic                      init_done;
   logic                      ena;
   logic                      enb;
   logic [BYTES_PER_LINE-1:0] wena;
   logic [BYTES_PER_LINE-1:0] wenb;
   logic [ADDR_WIDTH-1:0]     addra;
   logic [ADDR_WIDTH-1:0]     addrb;
   logic [LINE_SIZE-1:0]      dina;
   logic [LINE_SIZE-1:0]      dinb;
   logic [LINE_SIZE-1:0]      douta;
   logic [LINE_SIZE-1:0]      doutb;
   logic                      douta_valid;
   logic                      doutb_valid;

   modport master (
      input  init_done, douta, doutb, douta_valid, doutb_valid,
      output ena, enb, wena, wenb, addra, addrb, dina, dinb
   );

   modport slave (
      output init_done, douta, doutb, douta_valid, doutb_valid,
      input  ena, enb, wena, wenb, addra, addrb, dina, dinb
   );

endinterface

// File: rtl/mem_2rw_uram_rdpipe.sv
// Read-data delay line: STAGES async-reset registers carrying valid and data.
// Latency STAGES cycles; no backpressure, data registers only load on valid so output holds.
module mem_2rw_uram_rdpipe
   import mem_2rw_uram_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int STAGES = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_vld,
   input  logic [WIDTH-1:0] in_dat,
   output logic             out_vld,
   output logic [WIDTH-1:0] out_dat
);

   generate
      if (STAGES == 0) begin : g_pass
         assign out_vld = in_vld;
         assign out_dat = in_dat;
      end else begin : g_pipe
         logic [STAGES-1:0] vld_q;
         logic [STAGES-1:0] vld_d;
         logic [WIDTH-1:0]  dat_q [STAGES];
         logic [WIDTH-1:0]  dat_d [STAGES];

         always_comb begin
            vld_d    = '0;
            dat_d    = dat_q;
            vld_d[0] = in_vld;
            if (in_vld) dat_d[0] = in_dat;
            for (int i = 1; i < STAGES; i++) begin
               vld_d[i] = vld_q[i-1];
               if (vld_q[i-1]) dat_d[i] = dat_q[i-1];
            end
         end

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               vld_q <= '0;
               for (int i = 0; i < STAGES; i++) dat_q[i] <= '0;
            end else begin
               vld_q <= vld_d;
               dat_q <= dat_d;
            end
         end

         assign out_vld = vld_q[STAGES-1];
         assign out_dat = dat_q[STAGES-1];
      end
   endgenerate

endmodule

// File: rtl/mem_2rw_uram_pipe.sv
// True dual-port byte-enabled URAM line store; read latency READ_LATENCY with per-port valid, no backpressure.
// Optional hardware zero-fill after reset when MEM_2RW_URAM_HW_INIT_EN is defined.
module mem_2rw_uram_pipe
   import mem_2rw_uram_pkg::*;
#(
   parameter int BYTES_PER_LINE = 8,
   parameter int ADDR_WIDTH     = 12,
   parameter int READ_LATENCY   = 2
) (
   input  logic           clk,
   input  logic           rstn,
   mem_2rw_uram_if.slave  bus
);

   localparam int LINE_SIZE = 8 * BYTES_PER_LINE;
   localparam int DEPTH     = 2 ** ADDR_WIDTH;

   generate
      if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
         $error("mem_2rw_uram_pipe: READ_LATENCY %0d outside legal range", READ_LATENCY);
      end
   endgenerate

   logic [LINE_SIZE-1:0]      mem [DEPTH];
   logic                      ready;
   logic [BYTES_PER_LINE-1:0] wr_a;
   logic [BYTES_PER_LINE-1:0] wr_b;
   logic                      rd_a;
   logic                      rd_b;

`ifdef MEM_2RW_URAM_HW_INIT_EN
   mem_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  wr_init;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_init = 1'b0;
      if (state_q == INIT) begin
         wr_init = 1'b1;
         cnt_d   = cnt_q + 1'b1;
         if (cnt_q == '1) state_d = READY;
      end
   end

   assign ready = (state_q == READY);
`else
   logic ready_q, ready_d;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) ready_q <= 1'b0;
      else       ready_q <= ready_d;
   end

   assign ready_d = 1'b1;
   assign ready   = ready_q;
`endif

   assign wr_a = {BYTES_PER_LINE{bus.ena & ready}} & bus.wena;
   assign wr_b = {BYTES_PER_LINE{bus.enb & ready}} & bus.wenb;
   assign rd_a = bus.ena & ready & ~|bus.wena;
   assign rd_b = bus.enb & ready & ~|bus.wenb;

   // Port B writes are issued last so it owns any byte both ports hit in one cycle.
   always_ff @(posedge clk) begin
`ifdef MEM_2RW_URAM_HW_INIT_EN
      if (wr_init) mem[cnt_q] <= '0;
`endif
      for (int i = 0; i < BYTES_PER_LINE; i++) begin
         if (wr_a[i]) mem[bus.addra][8*i +: 8] <= bus.dina[8*i +: 8];
      end
      for (int i = 0; i < BYTES_PER_LINE; i++) begin
         if (wr_b[i]) mem[bus.addrb][8*i +: 8] <= bus.dinb[8*i +: 8];
      end
   end

   // URAM output register: samples the array before this edge's writes land (read-old).
   logic                 s1a_vld_q, s1a_vld_d, s1b_vld_q, s1b_vld_d;
   logic [LINE_SIZE-1:0] s1a_dat_q, s1a_dat_d, s1b_dat_q, s1b_dat_d;

   always_comb begin
      s1a_vld_d = rd_a;
      s1b_vld_d = rd_b;
      s1a_dat_d = s1a_dat_q;
      s1b_dat_d = s1b_dat_q;
      if (rd_a) s1a_dat_d = mem[bus.addra];
      if (rd_b) s1b_dat_d = mem[bus.addrb];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1a_vld_q <= 1'b0;
         s1b_vld_q <= 1'b0;
         s1a_dat_q <= '0;
         s1b_dat_q <= '0;
      end else begin
         s1a_vld_q <= s1a_vld_d;
         s1b_vld_q <= s1b_vld_d;
         s1a_dat_q <= s1a_dat_d;
         s1b_dat_q <= s1b_dat_d;
      end
   end

   mem_2rw_uram_rdpipe #(.WIDTH(LINE_SIZE), .STAGES(READ_LATENCY - 1)) u_rdpipe_a (
      .clk     (clk),
      .rstn    (rstn),
      .in_vld  (s1a_vld_q),
      .in_dat  (s1a_dat_q),
      .out_vld (bus.douta_valid),
      .out_dat (bus.douta)
   );

   mem_2rw_uram_rdpipe #(.WIDTH(LINE_SIZE), .STAGES(READ_LATENCY - 1)) u_rdpipe_b (
      .clk     (clk),
      .rstn    (rstn),
      .in_vld  (s1b_vld_q),
      .in_dat  (s1b_dat_q),
      .out_vld (bus.doutb_valid),
      .out_dat (bus.doutb)
   );

   assign bus.init_done = ready;

endmodule
